// File: rtl/nonce_ctrl.sv
// Nonce search controller: walks an inclusive nonce range through an external
// hash core and stops on the first hash whose two top bytes are below target.
module nonce_ctrl #(
   parameter int unsigned WDOG_CYCLES = 256
) (
   input  logic        clk,
   input  logic        reset_L,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] nonce_start,
   input  logic [31:0] nonce_end,
   input  logic [7:0]  target,
   output logic        hash_start,
   output logic [31:0] hash_nonce,
   input  logic        hash_done,
   input  logic [23:0] H,
   output logic        busy,
   output logic        done,
   output logic        valid,
   output logic        timeout,
   output logic [31:0] nonce_valido,
   output logic [23:0] bounty
);

   localparam int unsigned WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   localparam logic [WW-1:0] WDOG_MAX = WW'(WDOG_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, ISSUE, WAIT, CHECK, FIN
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   nonce_q, nonce_d;
   logic [31:0]   end_q, end_d;
   logic [7:0]    target_q, target_d;
   logic [23:0]   h_q, h_d;
   logic [WW-1:0] wdog_q, wdog_d;
   logic          valid_q, valid_d;
   logic          timeout_q, timeout_d;
   logic [31:0]   nv_q, nv_d;
   logic [23:0]   bounty_q, bounty_d;
   logic          pass;

   assign pass = (h_q[23:16] < target_q) && (h_q[15:8] < target_q);

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q   <= IDLE;
         nonce_q   <= '0;
         end_q     <= '0;
         target_q  <= '0;
         h_q       <= '0;
         wdog_q    <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         nv_q      <= '0;
         bounty_q  <= '0;
      end else begin
         state_q   <= state_d;
         nonce_q   <= nonce_d;
         end_q     <= end_d;
         target_q  <= target_d;
         h_q       <= h_d;
         wdog_q    <= wdog_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         nv_q      <= nv_d;
         bounty_q  <= bounty_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      nonce_d   = nonce_q;
      end_d     = end_q;
      target_d  = target_q;
      h_d       = h_q;
      wdog_d    = wdog_q;
      valid_d   = valid_q;
      timeout_d = timeout_q;
      nv_d      = nv_q;
      bounty_d  = bounty_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               nonce_d   = nonce_start;
               end_d     = nonce_end;
               target_d  = target;
               valid_d   = 1'b0;
               timeout_d = 1'b0;
               nv_d      = '0;
               bounty_d  = '0;
               state_d   = (nonce_start > nonce_end) ? FIN : ISSUE;
            end
         end
         ISSUE: begin
            if (abort) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end else begin
               wdog_d  = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // abort outranks a result arriving in the same cycle
            if (abort) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end else if (hash_done) begin
               h_d     = H;
               state_d = CHECK;
            end else if (wdog_q == WDOG_MAX) begin
               timeout_d = 1'b1;
               state_d   = FIN;
            end else begin
               wdog_d = wdog_q + WW'(1);
            end
         end
         CHECK: begin
            if (abort) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end else if (pass) begin
               nv_d     = nonce_q;
               bounty_d = h_q;
               valid_d  = 1'b1;
               state_d  = FIN;
            end else if (nonce_q == end_q) begin
               state_d = FIN;
            end else begin
               nonce_d = nonce_q + 32'd1;
               state_d = ISSUE;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign hash_start   = (state_q == ISSUE);
   assign hash_nonce   = nonce_q;
   assign busy         = (state_q != IDLE);
   assign done         = (state_q == FIN);
   assign valid        = valid_q;
   assign timeout      = timeout_q;
   assign nonce_valido = nv_q;
   assign bounty       = bounty_q;

endmodule

// File: tb/tb_nonce_ctrl.sv
// Directed bench for nonce_ctrl with a one-cycle-latency hash responder.
module tb_nonce_ctrl;

   logic        clk = 1'b0;
   logic        reset_L = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] nonce_start = '0;
   logic [31:0] nonce_end = '0;
   logic [7:0]  target = '0;
   logic        hash_start;
   logic [31:0] hash_nonce;
   logic        hash_done = 1'b0;
   logic [23:0] H = '0;
   logic        busy, done, valid, timeout;
   logic [31:0] nonce_valido;
   logic [23:0] bounty;

   int          n_checks = 0;
   int          n_fail = 0;
   int          hs_cnt = 0;
   logic [31:0] last_nonce = '0;
   logic [31:0] pass_nonce = 32'hDEAD_0000;
   logic        resp_en = 1'b1;
   logic        hs_prev = 1'b0;
   logic [31:0] n_prev = '0;
   int          lat;
   int          done_seen;

   nonce_ctrl #(.WDOG_CYCLES(8)) dut (
      .clk(clk), .reset_L(reset_L), .start(start), .abort(abort),
      .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
      .hash_start(hash_start), .hash_nonce(hash_nonce), .hash_done(hash_done),
      .H(H), .busy(busy), .done(done), .valid(valid), .timeout(timeout),
      .nonce_valido(nonce_valido), .bounty(bounty)
   );

   always #5 clk = ~clk;

   // Pass pattern: 0F/01 < 10. Fail patterns hit the boundary (== 10) on either byte.
   function automatic logic [23:0] hfun(input logic [31:0] n);
      if (n == pass_nonce) return {8'h0F, 8'h01, n[7:0]};
      else if (n[0])       return {8'h10, 8'h00, n[7:0]};
      else                 return {8'h02, 8'h10, n[7:0]};
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         hash_done = resp_en && hs_prev;
         H         = hfun(n_prev);
         hs_prev   = hash_start;
         n_prev    = hash_nonce;
         if (hash_start) begin
            hs_cnt++;
            last_nonce = hash_nonce;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic launch(input logic [31:0] s, input logic [31:0] e, input logic [7:0] t);
      @(negedge clk);
      hs_cnt      = 0;
      nonce_start = s;
      nonce_end   = e;
      target      = t;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // lat = negedges after launch returns until done is seen; -1 if never
   task automatic wait_done(input int max);
      lat = -1;
      for (int i = 0; i <= max; i++) begin
         if (done) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #12;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_outs", {28'b0, valid, timeout, hash_start, |bounty}, 32'd0);
      check("rst_nv", nonce_valido, 32'd0);
      @(negedge clk);
      reset_L = 1'b1;

      // 5..9, pass at 7: nonces 5,6,7 at 3 cycles each, then FIN
      pass_nonce = 32'd7;
      launch(32'd5, 32'd9, 8'h10);
      wait_done(50);
      check("pass_lat", lat, 32'd9);
      check("pass_hs", hs_cnt, 32'd3);
      check("pass_valid", {31'b0, valid}, 32'd1);
      check("pass_nv", nonce_valido, 32'd7);
      check("pass_bounty", {8'b0, bounty}, 32'h000F_0107);
      @(negedge clk);
      check("pass_done1", {30'b0, done, busy}, 32'd0);
      check("pass_hold", {31'b0, valid}, 32'd1);

      // 0..2, nothing passes
      pass_nonce = 32'hDEAD_0000;
      launch(32'd0, 32'd2, 8'h10);
      wait_done(50);
      check("nopass_seen", {31'b0, lat >= 0}, 32'd1);
      check("nopass_hs", hs_cnt, 32'd3);
      check("nopass_valid", {31'b0, valid}, 32'd0);
      check("nopass_clr", nonce_valido, 32'd0);

      // top of range: must stop at FFFFFFFF, never wrap
      launch(32'hFFFF_FFFE, 32'hFFFF_FFFF, 8'h10);
      wait_done(50);
      check("top_seen", {31'b0, lat >= 0}, 32'd1);
      repeat (5) @(negedge clk);
      check("top_hs", hs_cnt, 32'd2);
      check("top_last", last_nonce, 32'hFFFF_FFFF);
      check("top_busy", {31'b0, busy}, 32'd0);

      // empty range goes straight to FIN
      launch(32'd10, 32'd3, 8'h10);
      check("empty_done", {31'b0, done}, 32'd1);
      check("empty_hs", hs_cnt, 32'd0);
      @(negedge clk);
      check("empty_end", {30'b0, done, busy}, 32'd0);
      check("empty_valid", {31'b0, valid}, 32'd0);

      // watchdog: ISSUE, 8 cycles in WAIT, FIN
      resp_en = 1'b0;
      launch(32'd0, 32'd5, 8'h10);
      wait_done(50);
      check("wdog_lat", lat, 32'd9);
      check("wdog_to", {31'b0, timeout}, 32'd1);
      check("wdog_hs", hs_cnt, 32'd1);
      check("wdog_valid", {31'b0, valid}, 32'd0);
      resp_en = 1'b1;
      @(negedge clk);

      // abort together with a passing hash_done
      pass_nonce = 32'd7;
      launch(32'd7, 32'd7, 8'h10);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_to", {31'b0, timeout}, 32'd0);
      done_seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (done) done_seen = 1;
         @(negedge clk);
      end
      check("abort_nodone", done_seen, 32'd0);
      check("abort_valid", {31'b0, valid}, 32'd0);

      // reset together with a passing hash_done
      launch(32'd7, 32'd7, 8'h10);
      @(negedge clk);
      reset_L = 1'b0;
      #1;
      check("rstmid_busy", {30'b0, busy, hash_start}, 32'd0);
      @(negedge clk);
      reset_L = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (done || busy) done_seen = 1;
         @(negedge clk);
      end
      check("rstmid_idle", done_seen, 32'd0);
      check("rstmid_valid", {31'b0, valid}, 32'd0);
      check("rstmid_nonce", hash_nonce, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
